// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, fixed destination registers and arbiter state encoding
// for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int BYTE_W = 8;
  localparam int AGE_W  = 4;

  localparam logic [ADDR_W-1:0] K0_REG    = 5'd26;
  localparam logic [ADDR_W-1:0] UART_REG0 = 5'd4;
  localparam logic [ADDR_W-1:0] UART_REG1 = 5'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  function automatic logic [ADDR_W-1:0] uart_dest(input logic flag);
    return flag ? UART_REG1 : UART_REG0;
  endfunction

  function automatic logic [DATA_W-1:0] uart_word(input logic [BYTE_W-1:0] b);
    return {{(DATA_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wr_buffer.sv
// Single-entry write buffer. OVERWRITE=1 lets a new load replace a pending
// entry; OVERWRITE=0 drops it and sets a sticky overrun flag instead.
module regfile_write_arbiter_wr_buffer #(
  parameter int W         = 8,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         valid,
  output logic         valid_next,
  output logic [W-1:0] data,
  output logic         overrun
);

  logic         valid_r, valid_next_s;
  logic [W-1:0] data_r, data_next_s;
  logic         overrun_r, overrun_next_s;

  // Next entry state: a drain in the same cycle frees the slot for a load
  always_comb begin
    valid_next_s   = valid_r;
    data_next_s    = data_r;
    overrun_next_s = overrun_r;
    if (load) begin
      if (OVERWRITE || !valid_r || drain) begin
        valid_next_s = 1'b1;
        data_next_s  = load_data;
      end else begin
        overrun_next_s = 1'b1;
      end
    end else if (drain) begin
      valid_next_s = 1'b0;
    end else begin
      valid_next_s = valid_r;
    end
  end

  // Entry registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r   <= 1'b0;
      data_r    <= {W{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      valid_r   <= valid_next_s;
      data_r    <= data_next_s;
      overrun_r <= overrun_next_s;
    end
  end

  assign valid      = valid_r;
  assign valid_next = valid_next_s;
  assign data       = data_r;
  assign overrun    = overrun_r;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB passes straight through, exception PC
// saves and UART bytes are buffered and drained in WB idle slots.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exc_req,
  input  logic [DATA_W-1:0] exc_data,
  input  logic              uart_valid,
  input  logic              uart_flag,
  input  logic [BYTE_W-1:0] uart_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              pipe_stall,
  output logic              exc_pending,
  output logic              uart_overrun
);

  logic              wb_grant_s, exc_grant_s, uart_grant_s;
  logic              exc_valid_s, exc_valid_next_s, exc_overrun_unused_s;
  logic [DATA_W-1:0] exc_data_s;
  logic              uart_valid_s, uart_valid_next_s, uart_overrun_s;
  logic [BYTE_W:0]   uart_entry_s;
  logic              buf_grant_s, buf_valid_s, buf_valid_next_s;
  arb_state_e        state_r, state_next_s;
  logic [AGE_W-1:0]  age_r, age_next_s, age_inc_s;
  logic              pipe_stall_r;

  // A WB write to $zero is discarded and leaves the slot free for a buffer
  assign wb_grant_s   = wb_we && (wb_addr != {ADDR_W{1'b0}});
  assign exc_grant_s  = !wb_grant_s && exc_valid_s;
  assign uart_grant_s = !wb_grant_s && !exc_valid_s && uart_valid_s;

  regfile_write_arbiter_wr_buffer #(
    .W         (DATA_W),
    .OVERWRITE (1'b1)
  ) u_exc_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (exc_req),
    .load_data  (exc_data),
    .drain      (exc_grant_s),
    .valid      (exc_valid_s),
    .valid_next (exc_valid_next_s),
    .data       (exc_data_s),
    .overrun    (exc_overrun_unused_s)
  );

  regfile_write_arbiter_wr_buffer #(
    .W         (BYTE_W + 1),
    .OVERWRITE (1'b0)
  ) u_uart_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (uart_valid),
    .load_data  ({uart_flag, uart_data}),
    .drain      (uart_grant_s),
    .valid      (uart_valid_s),
    .valid_next (uart_valid_next_s),
    .data       (uart_entry_s),
    .overrun    (uart_overrun_s)
  );

  assign buf_grant_s      = exc_grant_s || uart_grant_s;
  assign buf_valid_s      = exc_valid_s || uart_valid_s;
  assign buf_valid_next_s = exc_valid_next_s || uart_valid_next_s;
  assign age_inc_s        = age_r + AGE_W'(1'b1);

  // Write-port mux in fixed priority WB > exception > UART
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = {ADDR_W{1'b0}};
    rf_data = {DATA_W{1'b0}};
    if (wb_grant_s) begin
      rf_we   = 1'b1;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (exc_valid_s) begin
      rf_we   = 1'b1;
      rf_addr = K0_REG;
      rf_data = exc_data_s;
    end else if (uart_valid_s) begin
      rf_we   = 1'b1;
      rf_addr = uart_dest(uart_entry_s[BYTE_W]);
      rf_data = uart_word(uart_entry_s[BYTE_W-1:0]);
    end else begin
      rf_we   = 1'b0;
    end
  end

  // Starvation FSM; transitions look at buffer occupancy after this edge
  always_comb begin
    state_next_s = state_r;
    age_next_s   = age_r;
    case (state_r)
      IDLE: begin
        age_next_s = {AGE_W{1'b0}};
        if (buf_valid_next_s) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (!buf_valid_next_s) begin
          state_next_s = IDLE;
          age_next_s   = {AGE_W{1'b0}};
        end else if (buf_grant_s) begin
          age_next_s   = {AGE_W{1'b0}};
        end else if (buf_valid_s) begin
          age_next_s = age_inc_s;
          if (age_inc_s >= AGE_W'(STARVE_MAX)) begin
            state_next_s = FORCE;
          end else begin
            state_next_s = WAIT;
          end
        end else begin
          age_next_s = age_r;
        end
      end
      FORCE: begin
        if (!buf_valid_next_s) begin
          state_next_s = IDLE;
          age_next_s   = {AGE_W{1'b0}};
        end else if (buf_grant_s) begin
          age_next_s   = {AGE_W{1'b0}};
        end else begin
          age_next_s   = age_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        age_next_s   = {AGE_W{1'b0}};
      end
    endcase
  end

  // State, age and stall registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      age_r        <= {AGE_W{1'b0}};
      pipe_stall_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      age_r        <= age_next_s;
      pipe_stall_r <= (state_next_s == FORCE);
    end
  end

  assign pipe_stall   = pipe_stall_r;
  assign exc_pending  = exc_valid_s;
  assign uart_overrun = uart_overrun_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector table, reset corner case and randomized run against a
// behavioural model of the write-port arbiter.
module tb_regfile_write_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exc_req;
  logic [31:0] exc_data;
  logic        uart_valid;
  logic        uart_flag;
  logic [7:0]  uart_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        pipe_stall;
  logic        exc_pending;
  logic        uart_overrun;

  regfile_write_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .exc_req      (exc_req),
    .exc_data     (exc_data),
    .uart_valid   (uart_valid),
    .uart_flag    (uart_flag),
    .uart_data    (uart_data),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .pipe_stall   (pipe_stall),
    .exc_pending  (exc_pending),
    .uart_overrun (uart_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        er;
    logic [31:0] ed;
    logic        uv;
    logic        uf;
    logic [7:0]  ub;
    logic        x_we;
    logic [4:0]  x_addr;
    logic [31:0] x_data;
    logic        x_stall;
    logic        x_excp;
    logic        x_ovr;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  // behavioural model state
  logic        m_exc_v, m_uart_v, m_uart_f, m_ovr, m_stall;
  logic [31:0] m_exc_d;
  logic [7:0]  m_uart_d;
  int          m_age;

  task automatic add(input logic we, input logic [4:0] a, input logic [31:0] d,
                     input logic er, input logic [31:0] ed,
                     input logic uv, input logic uf, input logic [7:0] ub,
                     input logic xwe, input logic [4:0] xa, input logic [31:0] xd,
                     input logic xs, input logic xp, input logic xo);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.er = er; v.ed = ed;
    v.uv = uv; v.uf = uf; v.ub = ub;
    v.x_we = xwe; v.x_addr = xa; v.x_data = xd;
    v.x_stall = xs; v.x_excp = xp; v.x_ovr = xo;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    exc_req = 1'b0; exc_data = 32'd0;
    uart_valid = 1'b0; uart_flag = 1'b0; uart_data = 8'd0;
  endtask

  task automatic check(input string name, input logic xwe, input logic [4:0] xa,
                       input logic [31:0] xd, input logic xs, input logic xp,
                       input logic xo);
    applied++;
    if ({rf_we, rf_addr, rf_data, pipe_stall, exc_pending, uart_overrun} !==
        {xwe, xa, xd, xs, xp, xo}) begin
      miscompares++;
      $display("FAIL %s: got we=%0b addr=%0d data=%h stall=%0b excp=%0b ovr=%0b, expected we=%0b addr=%0d data=%h stall=%0b excp=%0b ovr=%0b",
               name, rf_we, rf_addr, rf_data, pipe_stall, exc_pending, uart_overrun,
               xwe, xa, xd, xs, xp, xo);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_exc_v = 1'b0; m_uart_v = 1'b0; m_uart_f = 1'b0; m_ovr = 1'b0;
    m_stall = 1'b0; m_exc_d = 32'd0; m_uart_d = 8'd0; m_age = 0;
  endtask

  task automatic rand_cycle(input int idx);
    logic wb_g, eg, ug, pend, ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    @(posedge clk);
    #1;
    wb_we      = m_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
    wb_addr    = 5'($urandom_range(0, 31));
    wb_data    = $urandom;
    exc_req    = ($urandom_range(0, 15) == 0);
    exc_data   = $urandom;
    uart_valid = ($urandom_range(0, 5) == 0);
    uart_flag  = 1'($urandom_range(0, 1));
    uart_data  = 8'($urandom_range(0, 255));
    wb_g = wb_we && (wb_addr != 5'd0);
    eg   = !wb_g && m_exc_v;
    ug   = !wb_g && !m_exc_v && m_uart_v;
    ewe  = 1'b1;
    if (wb_g) begin
      ea = wb_addr; ed = wb_data;
    end else if (m_exc_v) begin
      ea = 5'd26; ed = m_exc_d;
    end else if (m_uart_v) begin
      ea = m_uart_f ? 5'd5 : 5'd4; ed = {24'd0, m_uart_d};
    end else begin
      ewe = 1'b0; ea = 5'd0; ed = 32'd0;
    end
    @(negedge clk);
    check($sformatf("rand[%0d]", idx), ewe, ea, ed, m_stall, m_exc_v, m_ovr);
    pend = m_exc_v || m_uart_v;
    if (exc_req) begin
      m_exc_v = 1'b1; m_exc_d = exc_data;
    end else if (eg) begin
      m_exc_v = 1'b0;
    end
    if (uart_valid) begin
      if (!m_uart_v || ug) begin
        m_uart_v = 1'b1; m_uart_f = uart_flag; m_uart_d = uart_data;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (ug) begin
      m_uart_v = 1'b0;
    end
    if (!m_exc_v && !m_uart_v) begin
      m_age = 0; m_stall = 1'b0;
    end else if (eg || ug) begin
      m_age = 0;
    end else if (pend) begin
      m_age++;
      if (m_age >= STARVE) m_stall = 1'b1;
    end
  endtask

  initial begin
    // single-WB write, and a dropped write to $zero
    add(1'b1, 5'd8, 32'h1234,   1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b1, 5'd8, 32'h1234,   1'b0, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0);
    add(1'b1, 5'd0, 32'hdead,   1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0);
    // exception save lands the cycle after the pulse
    add(1'b0, 5'd0, 32'h0, 1'b1, 32'h00400010, 1'b0, 1'b0, 8'h0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 8'h0, 1'b1, 5'd26, 32'h00400010, 1'b0, 1'b1, 1'b0);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 8'h0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0);
    // UART byte starved by six busy WB cycles
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hA5, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      add(1'b1, 5'd9, 32'h100 + i, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0,
          1'b1, 5'd9, 32'h100 + i, (i >= 4), 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1, 5'd5, 32'hA5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0);
    // exception and UART pending together
    add(1'b0, 5'd0, 32'h0, 1'b1, 32'hBFC00000, 1'b1, 1'b0, 8'h3C, 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 8'h0,  1'b1, 5'd26, 32'hBFC00000, 1'b0, 1'b1, 1'b0);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 8'h0,  1'b1, 5'd4, 32'h3C,       1'b0, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 8'h0,  1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0);
    // UART byte arriving while the previous one drains is accepted
    add(1'b1, 5'd7, 32'hAA, 1'b0, 32'h0, 1'b1, 1'b0, 8'h55, 1'b1, 5'd7, 32'hAA, 1'b0, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 8'h66, 1'b1, 5'd4, 32'h55, 1'b0, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b1, 5'd5, 32'h66, 1'b0, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0);
    // UART overrun while WB busy; first byte survives
    add(1'b1, 5'd10, 32'h50, 1'b0, 32'h0, 1'b1, 1'b0, 8'h11, 1'b1, 5'd10, 32'h50, 1'b0, 1'b0, 1'b0);
    add(1'b1, 5'd10, 32'h51, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b1, 5'd10, 32'h51, 1'b0, 1'b0, 1'b0);
    add(1'b1, 5'd10, 32'h52, 1'b0, 32'h0, 1'b1, 1'b0, 8'h22, 1'b1, 5'd10, 32'h52, 1'b0, 1'b0, 1'b0);
    add(1'b1, 5'd10, 32'h53, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b1, 5'd10, 32'h53, 1'b0, 1'b0, 1'b1);
    add(1'b0, 5'd0,  32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b1, 5'd4,  32'h11, 1'b0, 1'b0, 1'b1);
    add(1'b0, 5'd0,  32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 8'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 1'b1);
    // WB $k0 write overwritten by the later exception drain
    add(1'b0, 5'd0,  32'h0,  1'b1, 32'h80000180, 1'b0, 1'b0, 8'h0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
    add(1'b1, 5'd26, 32'h77, 1'b0, 32'h0,        1'b0, 1'b0, 8'h0, 1'b1, 5'd26, 32'h77,       1'b0, 1'b1, 1'b1);
    add(1'b0, 5'd0,  32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 8'h0, 1'b1, 5'd26, 32'h80000180, 1'b0, 1'b1, 1'b1);
    add(1'b0, 5'd0,  32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 8'h0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
    // newest PC wins; reload during drain keeps the buffer valid
    add(1'b1, 5'd3, 32'h1, 1'b1, 32'h100, 1'b0, 1'b0, 8'h0, 1'b1, 5'd3,  32'h1,   1'b0, 1'b0, 1'b1);
    add(1'b1, 5'd3, 32'h2, 1'b1, 32'h200, 1'b0, 1'b0, 8'h0, 1'b1, 5'd3,  32'h2,   1'b0, 1'b1, 1'b1);
    add(1'b0, 5'd0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, 8'h0, 1'b1, 5'd26, 32'h200, 1'b0, 1'b1, 1'b1);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, 8'h0, 1'b1, 5'd26, 32'h300, 1'b0, 1'b1, 1'b1);
    add(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, 8'h0, 1'b0, 5'd0,  32'h0,   1'b0, 1'b0, 1'b1);

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_reset();

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      wb_we = vecs[i].we; wb_addr = vecs[i].addr; wb_data = vecs[i].data;
      exc_req = vecs[i].er; exc_data = vecs[i].ed;
      uart_valid = vecs[i].uv; uart_flag = vecs[i].uf; uart_data = vecs[i].ub;
      @(negedge clk);
      check($sformatf("vec[%0d]", i), vecs[i].x_we, vecs[i].x_addr, vecs[i].x_data,
            vecs[i].x_stall, vecs[i].x_excp, vecs[i].x_ovr);
    end

    // reset in the middle of WAIT with both buffers full
    do_reset();
    @(posedge clk);
    #1;
    wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0;
    exc_req = 1'b1; exc_data = 32'hE0;
    uart_valid = 1'b1; uart_flag = 1'b1; uart_data = 8'h99;
    @(negedge clk);
    check("midwait_load", 1'b1, 5'd12, 32'hC0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    clear_inputs();
    wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'hC1;
    @(negedge clk);
    check("midwait_full", 1'b1, 5'd12, 32'hC1, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    wb_we = 1'b0;
    #1;
    check("reset_async", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset[%0d]", i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    end

    // randomized segments, each starting from reset
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 250; c++) rand_cycle(s * 250 + c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
